sdr_refresh: RTL

Periodic auto-refresh scheduler for the SDRAM controller, downstream of the power-up initialisation sequencer. It is enabled by the sequencer's `init_done` pulse, generates one refresh credit per tREFI interval, and requests the command bus from the controller arbiter. On grant it drives PRECHARGE-ALL followed by AUTO REFRESH with tRP/tRFC spacing, then releases the bus. Up to `MAX_PEND` refreshes can be postponed while the arbiter is busy with reads and writes.

---
 rtl/sdr_refresh.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sdr_refresh.sv
// Periodic SDRAM auto-refresh scheduler: accrues one credit per tREFI, requests the bus,
// then issues PRECHARGE-ALL + AUTO REFRESH. Define SDR_REF_BURST_EN to drain credits per grant.
module sdr_refresh #(
    parameter int unsigned T_REFI_CYC = 1300,
    parameter int unsigned N_RP       = 3,
    parameter int unsigned N_RFC      = 11,
    parameter int unsigned MAX_PEND   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        ref_ack,
    output logic        ref_req,
    output logic        ref_urgent,
    output logic        ref_busy,
    output logic        ref_done,
    output logic        ref_overflow,
    output logic [3:0]  pend_cnt,
    output logic        sdr_nRAS,
    output logic        sdr_nCAS,
    output logic        sdr_nWE,
    output logic [12:0] sdr_A,
    output logic [1:0]  sdr_BA
);

    localparam int unsigned CW   = (T_REFI_CYC > 1) ? $clog2(T_REFI_CYC) : 1;
    localparam int unsigned TMAX = (N_RP > N_RFC) ? N_RP : N_RFC;
    localparam int unsigned TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    localparam logic [2:0] CmdNop = 3'b111;
    localparam logic [2:0] CmdPre = 3'b010;
    localparam logic [2:0] CmdRef = 3'b001;

    typedef enum logic [1:0] {StOff, StIdle, StPre, StRef} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] ivl_q, ivl_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    pend_q, pend_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    cmd_q, cmd_d;
    logic          a10_q, a10_d;
    logic          tick;
    logic          ref_entry;

    assign tick = (state_q != StOff) && (ivl_q == CW'(T_REFI_CYC - 1));

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        ref_entry = 1'b0;
        cmd_d     = CmdNop;
        a10_d     = 1'b0;
        case (state_q)
            StOff: begin
                if (init_done) state_d = StIdle;
            end
            StIdle: begin
                if (req_q && ref_ack) begin
                    state_d = StPre;
                    tmr_d   = TW'(N_RP - 1);
                    cmd_d   = CmdPre;
                    a10_d   = 1'b1;
                end
            end
            StPre: begin
                // Credit count cannot drop while precharging, so it is still non-zero here.
                if (tmr_q == '0) begin
                    state_d   = StRef;
                    tmr_d     = TW'(N_RFC - 1);
                    ref_entry = 1'b1;
                    cmd_d     = CmdRef;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StRef: begin
                if (tmr_q == '0) begin
`ifdef SDR_REF_BURST_EN
                    if (pend_q != 4'd0) begin
                        tmr_d     = TW'(N_RFC - 1);
                        ref_entry = 1'b1;
                        cmd_d     = CmdRef;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = StOff;
        endcase
    end

    always_comb begin
        ivl_d  = '0;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (state_q != StOff && !tick) ivl_d = ivl_q + 1'b1;
        if (tick && !ref_entry) begin
            if (pend_q == 4'(MAX_PEND)) ovf_d = 1'b1;
            else                        pend_d = pend_q + 4'd1;
        end else if (ref_entry && !tick) begin
            pend_d = pend_q - 4'd1;
        end
        busy_d = (state_d == StPre) || (state_d == StRef);
        done_d = (state_q == StRef) && (state_d == StIdle);
        req_d  = (state_d == StIdle) && (pend_d != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StOff;
            ivl_q   <= '0;
            tmr_q   <= '0;
            pend_q  <= 4'd0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cmd_q   <= CmdNop;
            a10_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ivl_q   <= ivl_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            cmd_q   <= cmd_d;
            a10_q   <= a10_d;
        end
    end

    assign ref_req      = req_q;
    assign ref_urgent   = (pend_q == 4'(MAX_PEND));
    assign ref_busy     = busy_q;
    assign ref_done     = done_q;
    assign ref_overflow = ovf_q;
    assign pend_cnt     = pend_q;
    assign sdr_nRAS     = cmd_q[2];
    assign sdr_nCAS     = cmd_q[1];
    assign sdr_nWE      = cmd_q[0];
    assign sdr_A        = {2'b00, a10_q, 10'b0};
    assign sdr_BA       = 2'b00;

endmodule
